// File: rtl/homo_query_arbiter.sv
// ============================================================================
// homo_query_arbiter : round-robin sharing of one homography engine between
// two requesters, with in-order response routing and flush/drain.
// Optional: define HQA_TAG_CHECK_EN to check echoed coordinates on return.
// Revision: 1.0
// ============================================================================
`default_nettype none

module homo_query_arbiter #(
  parameter int MAX_OUT = 8,
  parameter int CNT_W   = 4
) (
  input  logic       clk_25,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       req0_valid,
  input  logic [9:0] req0_x,
  input  logic [9:0] req0_y,
  output logic       req0_ack,
  input  logic       req1_valid,
  input  logic [9:0] req1_x,
  input  logic [9:0] req1_y,
  output logic       req1_ack,
  output logic [9:0] query_x,
  output logic [9:0] query_y,
  output logic       start,
  input  logic       ready,
  input  logic [9:0] return_x,
  input  logic [9:0] return_y,
  input  logic [4:0] r,
  input  logic [5:0] g,
  input  logic [4:0] b,
  output logic       rsp0_val,
  output logic [9:0] rsp0_x,
  output logic [9:0] rsp0_y,
  output logic [4:0] rsp0_r,
  output logic [5:0] rsp0_g,
  output logic [4:0] rsp0_b,
  output logic       rsp1_val,
  output logic [9:0] rsp1_x,
  output logic [9:0] rsp1_y,
  output logic [4:0] rsp1_r,
  output logic [5:0] rsp1_g,
  output logic [4:0] rsp1_b,
  output logic       busy,
  output logic       flush_done,
  output logic       err_orphan,
  output logic       err_mismatch
);

  localparam int PTR_W = $clog2(MAX_OUT);
`ifdef HQA_TAG_CHECK_EN
  localparam int ENTRY_W = 21;
`else
  localparam int ENTRY_W = 1;
`endif

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_DRAIN   = 2'd1,
    S_WAITREL = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_outstanding;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [ENTRY_W-1:0] r_fifo [MAX_OUT];
  logic               r_rr_last;
  logic               w_can_grant;
  logic               w_ack0;
  logic               w_ack1;
  logic               w_ack;
  logic               w_pop;
  logic               w_head_id;
  logic [ENTRY_W-1:0] w_push_entry;
  logic [ENTRY_W-1:0] w_head;

  assign w_can_grant = (r_state == S_RUN) && (r_outstanding < CNT_W'(MAX_OUT));
  // On a tie the requester that did not win last time gets the slot.
  assign w_ack0 = w_can_grant & req0_valid & (~req1_valid | r_rr_last);
  assign w_ack1 = w_can_grant & req1_valid & (~req0_valid | ~r_rr_last);
  assign w_ack  = w_ack0 | w_ack1;
  assign req0_ack = w_ack0;
  assign req1_ack = w_ack1;

  assign w_pop  = ready && (r_outstanding != '0);
  assign w_head = r_fifo[r_rd_ptr];
  assign busy   = (r_outstanding != '0);

`ifdef HQA_TAG_CHECK_EN
  assign w_push_entry = w_ack1 ? {1'b1, req1_x, req1_y} : {1'b0, req0_x, req0_y};
  assign w_head_id    = w_head[20];
`else
  assign w_push_entry = w_ack1;
  assign w_head_id    = w_head[0];
`endif

  always_comb begin
    w_cnt_next = r_outstanding;
    case ({w_ack, w_pop})
      2'b10:   w_cnt_next = r_outstanding + 1'b1;
      2'b01:   w_cnt_next = r_outstanding - 1'b1;
      default: w_cnt_next = r_outstanding;
    endcase
  end

  always_ff @(posedge clk_25) begin
    if (w_ack) begin
      r_fifo[r_wr_ptr] <= w_push_entry;
    end
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_RUN;
      r_outstanding <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_rr_last     <= 1'b1;
      start         <= 1'b0;
      query_x       <= '0;
      query_y       <= '0;
      rsp0_val      <= 1'b0;
      rsp0_x        <= '0;
      rsp0_y        <= '0;
      rsp0_r        <= '0;
      rsp0_g        <= '0;
      rsp0_b        <= '0;
      rsp1_val      <= 1'b0;
      rsp1_x        <= '0;
      rsp1_y        <= '0;
      rsp1_r        <= '0;
      rsp1_g        <= '0;
      rsp1_b        <= '0;
      flush_done    <= 1'b0;
      err_orphan    <= 1'b0;
    end else begin
      r_outstanding <= w_cnt_next;
      start         <= w_ack;
      flush_done    <= 1'b0;
      if (w_ack) begin
        r_wr_ptr  <= r_wr_ptr + 1'b1;
        r_rr_last <= w_ack1;
        query_x   <= w_ack1 ? req1_x : req0_x;
        query_y   <= w_ack1 ? req1_y : req0_y;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      rsp0_val <= w_pop & ~w_head_id;
      rsp1_val <= w_pop & w_head_id;
      if (w_pop && !w_head_id) begin
        rsp0_x <= return_x;
        rsp0_y <= return_y;
        rsp0_r <= r;
        rsp0_g <= g;
        rsp0_b <= b;
      end
      if (w_pop && w_head_id) begin
        rsp1_x <= return_x;
        rsp1_y <= return_y;
        rsp1_r <= r;
        rsp1_g <= g;
        rsp1_b <= b;
      end
      if (ready && (r_outstanding == '0)) begin
        err_orphan <= 1'b1;
      end
      // Drain completion looks at the next count so flush_done lands with the last response.
      case (r_state)
        S_RUN: begin
          if (flush) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_cnt_next == '0) begin
            flush_done <= 1'b1;
            r_state    <= S_WAITREL;
          end
        end
        S_WAITREL: begin
          if (!flush) r_state <= S_RUN;
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

`ifdef HQA_TAG_CHECK_EN
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      err_mismatch <= 1'b0;
    end else if (w_pop && (w_head[19:0] != {return_x, return_y})) begin
      err_mismatch <= 1'b1;
    end
  end
`else
  assign err_mismatch = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_homo_query_arbiter.sv
// ============================================================================
// tb_homo_query_arbiter : directed table vectors plus hand-written sequences.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_homo_query_arbiter;

  logic       clk_25 = 1'b0;
  logic       rst_n, flush;
  logic       req0_valid, req1_valid, req0_ack, req1_ack;
  logic [9:0] req0_x, req0_y, req1_x, req1_y, query_x, query_y;
  logic       start, ready;
  logic [9:0] return_x, return_y;
  logic [4:0] r, b;
  logic [5:0] g;
  logic       rsp0_val, rsp1_val;
  logic [9:0] rsp0_x, rsp0_y, rsp1_x, rsp1_y;
  logic [4:0] rsp0_r, rsp0_b, rsp1_r, rsp1_b;
  logic [5:0] rsp0_g, rsp1_g;
  logic       busy, flush_done, err_orphan, err_mismatch;

  int n_cmp = 0;
  int n_err = 0;

`ifdef HQA_TAG_CHECK_EN
  localparam logic EXP_MM = 1'b1;
`else
  localparam logic EXP_MM = 1'b0;
`endif

  homo_query_arbiter #(.MAX_OUT(8), .CNT_W(4)) dut (
    .clk_25(clk_25), .rst_n(rst_n), .flush(flush),
    .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y), .req0_ack(req0_ack),
    .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y), .req1_ack(req1_ack),
    .query_x(query_x), .query_y(query_y), .start(start), .ready(ready),
    .return_x(return_x), .return_y(return_y), .r(r), .g(g), .b(b),
    .rsp0_val(rsp0_val), .rsp0_x(rsp0_x), .rsp0_y(rsp0_y),
    .rsp0_r(rsp0_r), .rsp0_g(rsp0_g), .rsp0_b(rsp0_b),
    .rsp1_val(rsp1_val), .rsp1_x(rsp1_x), .rsp1_y(rsp1_y),
    .rsp1_r(rsp1_r), .rsp1_g(rsp1_g), .rsp1_b(rsp1_b),
    .busy(busy), .flush_done(flush_done),
    .err_orphan(err_orphan), .err_mismatch(err_mismatch)
  );

  always #20 clk_25 = ~clk_25;

  typedef struct {
    logic       pre_rst;
    logic       v0; logic [9:0] x0; logic [9:0] y0;
    logic       v1; logic [9:0] x1; logic [9:0] y1;
    logic       rdy; logic [9:0] rx; logic [9:0] ry;
    logic [4:0] cr; logic [5:0] cg; logic [4:0] cb;
    logic       e_ack0; logic e_ack1; logic e_start;
    logic [9:0] e_qx; logic [9:0] e_qy;
    logic       e_rsp0; logic e_rsp1; logic e_busy;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_25);
    #1;
  endtask

  task automatic set_req(input logic v0, input logic [9:0] x0, input logic [9:0] y0,
                         input logic v1, input logic [9:0] x1, input logic [9:0] y1);
    req0_valid = v0; req0_x = x0; req0_y = y0;
    req1_valid = v1; req1_x = x1; req1_y = y1;
  endtask

  task automatic set_rdy(input logic rd, input logic [9:0] rx, input logic [9:0] ry);
    ready = rd; return_x = rx; return_y = ry;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    set_req(0, 0, 0, 0, 0, 0);
    set_rdy(0, 0, 0);
    r = '0; g = '0; b = '0;
    repeat (2) @(posedge clk_25);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic apply(input vec_t v, input int i);
    if (v.pre_rst) do_reset();
    set_req(v.v0, v.x0, v.y0, v.v1, v.x1, v.y1);
    set_rdy(v.rdy, v.rx, v.ry);
    r = v.cr; g = v.cg; b = v.cb;
    #1;
    chk($sformatf("v%0d.ack0", i), req0_ack, v.e_ack0);
    chk($sformatf("v%0d.ack1", i), req1_ack, v.e_ack1);
    tick();
    chk($sformatf("v%0d.start", i), start, v.e_start);
    chk($sformatf("v%0d.query", i), {query_x, query_y}, {v.e_qx, v.e_qy});
    chk($sformatf("v%0d.rsp0_val", i), rsp0_val, v.e_rsp0);
    chk($sformatf("v%0d.rsp1_val", i), rsp1_val, v.e_rsp1);
    chk($sformatf("v%0d.busy", i), busy, v.e_busy);
    if (v.e_rsp0)
      chk($sformatf("v%0d.rsp0_data", i), {rsp0_x, rsp0_y, rsp0_r, rsp0_g, rsp0_b},
          {v.rx, v.ry, v.cr, v.cg, v.cb});
    if (v.e_rsp1)
      chk($sformatf("v%0d.rsp1_data", i), {rsp1_x, rsp1_y, rsp1_r, rsp1_g, rsp1_b},
          {v.rx, v.ry, v.cr, v.cg, v.cb});
  endtask

  initial begin
    logic       id;
    logic [9:0] nx, ny;
    logic       q_id [$];
    logic [9:0] q_x [$];
    logic [9:0] q_y [$];
    int         n_r;

    // Fields: rst, v0 x0 y0, v1 x1 y1, rdy rx ry, r g b, ack0 ack1 start qx qy rsp0 rsp1 busy
    vecs[0]  = '{1, 1,3,7,     0,0,0,     0,0,0,     0,0,0,    1,0,1,3,7,     0,0,1};
    vecs[1]  = '{0, 0,0,0,     0,0,0,     0,0,0,     0,0,0,    0,0,0,3,7,     0,0,1};
    vecs[2]  = '{0, 0,0,0,     0,0,0,     0,0,0,     0,0,0,    0,0,0,3,7,     0,0,1};
    vecs[3]  = '{0, 0,0,0,     0,0,0,     0,0,0,     0,0,0,    0,0,0,3,7,     0,0,1};
    vecs[4]  = '{0, 0,0,0,     0,0,0,     1,3,7,     17,42,12, 0,0,0,3,7,     1,0,0};
    vecs[5]  = '{0, 0,0,0,     0,0,0,     0,0,0,     0,0,0,    0,0,0,3,7,     0,0,0};
    vecs[6]  = '{1, 1,100,200, 1,300,400, 0,0,0,     0,0,0,    1,0,1,100,200, 0,0,1};
    vecs[7]  = '{0, 1,100,200, 1,300,400, 1,100,200, 1,2,3,    0,1,1,300,400, 1,0,1};
    vecs[8]  = '{0, 1,100,200, 1,300,400, 1,300,400, 4,5,6,    1,0,1,100,200, 0,1,1};
    vecs[9]  = '{0, 1,100,200, 1,300,400, 1,100,200, 7,8,9,    0,1,1,300,400, 1,0,1};
    vecs[10] = '{0, 1,100,200, 1,300,400, 1,300,400, 10,11,12, 1,0,1,100,200, 0,1,1};
    vecs[11] = '{0, 1,100,200, 1,300,400, 1,100,200, 13,14,15, 0,1,1,300,400, 1,0,1};
    vecs[12] = '{0, 0,0,0,     0,0,0,     1,300,400, 16,17,18, 0,0,0,300,400, 0,1,0};
    vecs[13] = '{0, 0,0,0,     0,0,0,     0,0,0,     0,0,0,    0,0,0,300,400, 0,0,0};

    do_reset();
    #1;
    chk("rst.acks", {req0_ack, req1_ack}, 2'b00);
    chk("rst.outs", {start, query_x, query_y, rsp0_val, rsp1_val, busy, flush_done,
                     err_orphan, err_mismatch}, '0);
    chk("rst.rsp_data", {rsp0_x, rsp0_y, rsp0_r, rsp0_g, rsp0_b,
                         rsp1_x, rsp1_y, rsp1_r, rsp1_g, rsp1_b}, '0);

    for (int i = 0; i < 14; i++) apply(vecs[i], i);

    // Full: eight acks, then a ready frees exactly one slot on the following cycle
    do_reset();
    set_req(0, 0, 0, 1, 9, 9);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("full.ack1[%0d]", i), req1_ack, (i < 8));
      tick();
    end
    chk("full.busy", busy, 1'b1);
    set_rdy(1, 9, 9);
    #1;
    chk("full.ack_same_cycle", req1_ack, 1'b0);
    tick();
    chk("full.rsp1_val", rsp1_val, 1'b1);
    set_rdy(0, 0, 0);
    #1;
    chk("full.ack_next_cycle", req1_ack, 1'b1);
    tick();
    #1;
    chk("full.ack_refull", req1_ack, 1'b0);
    set_req(0, 0, 0, 0, 0, 0);
    set_rdy(1, 9, 9);
    repeat (8) tick();
    set_rdy(0, 0, 0);
    chk("full.drained", busy, 1'b0);

    // Simultaneous ack+ready at 5 outstanding; scoreboard tracks routing through pointer wrap
    do_reset();
    for (int i = 0; i < 5; i++) begin
      id = (i % 3 == 0);
      nx = 10'(i + 1); ny = 10'(500 + i);
      set_req(!id, nx, ny, id, nx, ny);
      #1;
      chk($sformatf("wrap.fill_ack[%0d]", i), {req1_ack, req0_ack}, id ? 2'b10 : 2'b01);
      q_id.push_back(id); q_x.push_back(nx); q_y.push_back(ny);
      tick();
    end
    for (int k = 0; k < 20; k++) begin
      id = (k % 3 == 1);
      nx = 10'(50 + k); ny = 10'(600 + k);
      set_req(!id, nx, ny, id, nx, ny);
      set_rdy(1, q_x[0], q_y[0]);
      #1;
      chk($sformatf("wrap.ack[%0d]", k), {req1_ack, req0_ack}, id ? 2'b10 : 2'b01);
      tick();
      chk($sformatf("wrap.query[%0d]", k), {start, query_x, query_y}, {1'b1, nx, ny});
      chk($sformatf("wrap.rsp_val[%0d]", k), {rsp1_val, rsp0_val}, q_id[0] ? 2'b10 : 2'b01);
      chk($sformatf("wrap.rsp_xy[%0d]", k),
          q_id[0] ? {rsp1_x, rsp1_y} : {rsp0_x, rsp0_y}, {q_x[0], q_y[0]});
      chk($sformatf("wrap.busy[%0d]", k), busy, 1'b1);
      void'(q_id.pop_front()); void'(q_x.pop_front()); void'(q_y.pop_front());
      q_id.push_back(id); q_x.push_back(nx); q_y.push_back(ny);
    end
    set_req(0, 0, 0, 0, 0, 0);
    for (int j = 0; j < 5; j++) begin
      set_rdy(1, q_x[0], q_y[0]);
      tick();
      chk($sformatf("wrap.drain_val[%0d]", j), {rsp1_val, rsp0_val}, q_id[0] ? 2'b10 : 2'b01);
      chk($sformatf("wrap.drain_xy[%0d]", j),
          q_id[0] ? {rsp1_x, rsp1_y} : {rsp0_x, rsp0_y}, {q_x[0], q_y[0]});
      void'(q_id.pop_front()); void'(q_x.pop_front()); void'(q_y.pop_front());
    end
    set_rdy(0, 0, 0);
    chk("wrap.busy_end", busy, 1'b0);

    // Flush with three queries in flight
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_req(1, 10'(20 + i), 10'(30 + i), 0, 0, 0);
      tick();
    end
    set_req(0, 0, 0, 0, 0, 0);
    flush = 1'b1;
    tick();
    set_req(1, 5, 5, 0, 0, 0);
    n_r = 0;
    for (int j = 0; j < 8; j++) begin
      if (j == 1 || j == 2 || j == 4) begin
        set_rdy(1, 10'(20 + n_r), 10'(30 + n_r));
        n_r++;
      end else begin
        set_rdy(0, 0, 0);
      end
      #1;
      chk($sformatf("flush.ack0[%0d]", j), req0_ack, 1'b0);
      tick();
      chk($sformatf("flush.done[%0d]", j), flush_done, (j == 4));
    end
    set_rdy(0, 0, 0);
    flush = 1'b0;
    #1;
    chk("flush.ack_waitrel", req0_ack, 1'b0);
    tick();
    #1;
    chk("flush.ack_resume", req0_ack, 1'b1);
    tick();
    chk("flush.start_resume", start, 1'b1);

    // Flush with nothing outstanding: RUN -> DRAIN -> WAITREL, single pulse
    do_reset();
    flush = 1'b1;
    tick();
    chk("flush0.done_c1", flush_done, 1'b0);
    tick();
    chk("flush0.done_c2", flush_done, 1'b1);
    tick();
    chk("flush0.done_c3", flush_done, 1'b0);
    flush = 1'b0;
    tick();

    // Orphan ready, and ready after a mid-operation reset
    do_reset();
    set_rdy(1, 5, 5);
    tick();
    set_rdy(0, 0, 0);
    chk("orphan.flag", err_orphan, 1'b1);
    chk("orphan.no_rsp", {rsp0_val, rsp1_val, busy}, 3'b000);
    repeat (3) tick();
    chk("orphan.sticky", err_orphan, 1'b1);
    do_reset();
    chk("orphan.cleared", err_orphan, 1'b0);
    set_req(1, 4, 4, 0, 0, 0);
    tick();
    do_reset();
    set_rdy(1, 4, 4);
    tick();
    set_rdy(0, 0, 0);
    chk("rst_mid.orphan", err_orphan, 1'b1);
    chk("rst_mid.no_rsp", rsp0_val, 1'b0);

    // Echoed coordinate differs from the issued one
    do_reset();
    set_req(1, 1, 3, 0, 0, 0);
    tick();
    set_req(0, 0, 0, 0, 0, 0);
    chk("mm.pre", err_mismatch, 1'b0);
    set_rdy(1, 1, 2);
    tick();
    set_rdy(0, 0, 0);
    chk("mm.rsp_delivered", {rsp0_val, rsp0_x, rsp0_y}, {1'b1, 10'd1, 10'd2});
    chk("mm.flag", err_mismatch, EXP_MM);
    tick();
    chk("mm.sticky", err_mismatch, EXP_MM);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
